// File: rtl/rice_core_mul_ctrl.sv
// rice_core_mul_ctrl
//   Sequencer between the execute-stage issue logic and the iterative radix-4
//   multiplier rice_core_mul. It takes one multiply request at a time over a
//   valid/ready handshake. It holds the latched operands on the multiplier
//   inputs for the whole iteration and returns the result through a
//   back-pressurable response port. It handles flush, including draining the
//   non-abortable multiplier. A one-entry result cache answers a repeated
//   identical request in one cycle.
//
//   Operation encoding (one-hot, 4 bits): bit0 MUL, bit1 MULH,
//   bit2 MULHSU, bit3 MULHU.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_flush                     kill the current request
//   i_req_valid/o_req_ready     request handshake (ready only in IDLE)
//   i_req_rs1/rs2/operation     request operands and operation
//   o_rsp_valid/i_rsp_ready     response handshake
//   o_rsp_data                  registered result
//   o_mul_valid                 one-cycle start pulse to the multiplier
//   o_mul_rs1/rs2/operation     latched operands to the multiplier
//   i_mul_result_valid          multiplier last-iteration pulse
//   i_mul_result                multiplier result
//   o_busy                      high whenever the sequencer is not idle
module rice_core_mul_ctrl #(
  parameter int XLEN     = 32,
  parameter int CACHE_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_req_rs1,
  input  logic [XLEN-1:0] i_req_rs2,
  input  logic [3:0]      i_req_operation,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_mul_valid,
  output logic [XLEN-1:0] o_mul_rs1,
  output logic [XLEN-1:0] o_mul_rs2,
  output logic [3:0]      o_mul_operation,
  input  logic            i_mul_result_valid,
  input  logic [XLEN-1:0] i_mul_result,
  output logic            o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] rsp_data_q;
  logic            rsp_valid_q;

  logic            cache_vld_q;
  logic [3:0]      cache_op_q;
  logic [XLEN-1:0] cache_rs1_q, cache_rs2_q, cache_data_q;

  logic accept;
  logic cache_hit;
  logic capture;

  assign accept    = i_req_valid && (state_q == S_IDLE) && !i_flush;
  // The lookup compares the incoming request, not the latched registers,
  // so a hit can be answered in the accept cycle's next state.
  assign cache_hit = (CACHE_EN != 0) && cache_vld_q &&
                     (i_req_operation == cache_op_q) &&
                     (i_req_rs1 == cache_rs1_q) &&
                     (i_req_rs2 == cache_rs2_q);
  // A result coinciding with a flush is discarded and never cached.
  assign capture   = (state_q == S_BUSY) && i_mul_result_valid && !i_flush;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = cache_hit ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = i_flush ? S_IDLE : S_BUSY;
      S_BUSY: begin
        if (i_mul_result_valid) state_d = i_flush ? S_IDLE : S_RESP;
        else if (i_flush)       state_d = S_DRAIN;
      end
      // The multiplier cannot be aborted; wait out its final pulse.
      S_DRAIN: if (i_mul_result_valid) state_d = S_IDLE;
      S_RESP:  if (i_flush || i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_req_ready = (state_q == S_IDLE);
    o_mul_valid = (state_q == S_ISSUE) && !i_flush;
    o_busy      = (state_q != S_IDLE);
  end

  // Operand latch, response register and result cache
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs1_q        <= '0;
      rs2_q        <= '0;
      op_q         <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      cache_vld_q  <= 1'b0;
      cache_op_q   <= '0;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_data_q <= '0;
    end else begin
      rsp_valid_q <= (state_d == S_RESP);
      if (accept) begin
        rs1_q <= i_req_rs1;
        rs2_q <= i_req_rs2;
        op_q  <= i_req_operation;
        if (cache_hit) rsp_data_q <= cache_data_q;
      end
      if (capture) begin
        rsp_data_q   <= i_mul_result;
        cache_vld_q  <= 1'b1;
        cache_op_q   <= op_q;
        cache_rs1_q  <= rs1_q;
        cache_rs2_q  <= rs2_q;
        cache_data_q <= i_mul_result;
      end
    end
  end

  assign o_mul_rs1       = rs1_q;
  assign o_mul_rs2       = rs2_q;
  assign o_mul_operation = op_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_data      = rsp_data_q;

endmodule

// File: tb/tb_rice_core_mul_ctrl.sv
module tb_rice_core_mul_ctrl;
  localparam int XLEN = 32;
  localparam logic [3:0] OP_MUL    = 4'b0001;
  localparam logic [3:0] OP_MULH   = 4'b0010;
  localparam logic [3:0] OP_MULHSU = 4'b0100;
  localparam logic [3:0] OP_MULHU  = 4'b1000;

  logic            clk;
  logic            rst_n;
  logic            i_flush;
  logic            i_req_valid;
  logic            o_req_ready;
  logic [XLEN-1:0] i_req_rs1, i_req_rs2;
  logic [3:0]      i_req_operation;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [XLEN-1:0] o_rsp_data;
  logic            o_mul_valid;
  logic [XLEN-1:0] o_mul_rs1, o_mul_rs2;
  logic [3:0]      o_mul_operation;
  logic            i_mul_result_valid;
  logic [XLEN-1:0] i_mul_result;
  logic            o_busy;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  rice_core_mul_ctrl #(.XLEN(XLEN), .CACHE_EN(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_rs1(i_req_rs1), .i_req_rs2(i_req_rs2), .i_req_operation(i_req_operation),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_mul_valid(o_mul_valid), .o_mul_rs1(o_mul_rs1), .o_mul_rs2(o_mul_rs2),
    .o_mul_operation(o_mul_operation),
    .i_mul_result_valid(i_mul_result_valid), .i_mul_result(i_mul_result),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b};             return p[31:0];  end
      OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
      default:   begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
    endcase
  endfunction

  // Multiplier model: the start pulse in cycle t+1 yields the result pulse
  // (XLEN+2)/2 cycles later, in cycle t+18.
  int              mcnt;
  logic [XLEN-1:0] mres;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      mres <= '0;
    end else if (o_mul_valid) begin
      mcnt <= (XLEN + 2) / 2;
      mres <= ref_mul(o_mul_operation, o_mul_rs1, o_mul_rs2);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign i_mul_result_valid = (mcnt == 1);
  assign i_mul_result       = (mcnt == 1) ? mres : 32'hDEAD_BEEF;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit push, output bit rdy);
    cyc();
    i_req_valid = 1'b1; i_req_operation = op; i_req_rs1 = a; i_req_rs2 = b;
    #1;
    rdy = o_req_ready;
    if (push) exp_q.push_back(exp);
  endtask

  // Cycle k=1 is the cycle after accept. Request inputs are scrambled after
  // accept so that anything not latched shows up as a wrong result.
  task automatic wait_rsp(input int maxc, output int lat, output int mv_first, output int mv_cnt,
                          output int op_chg, output logic [31:0] r1, output logic [31:0] r2,
                          output logic [3:0] o);
    lat = -1; mv_first = -1; mv_cnt = 0; op_chg = 0; r1 = '0; r2 = '0; o = '0;
    for (int k = 1; k <= maxc; k++) begin
      cyc();
      i_req_valid = 1'b0; i_req_rs1 = $urandom; i_req_rs2 = $urandom;
      #1;
      if (k == 1) begin
        r1 = o_mul_rs1; r2 = o_mul_rs2; o = o_mul_operation;
      end else if (o_mul_rs1 !== r1 || o_mul_rs2 !== r2 || o_mul_operation !== o) begin
        op_chg++;
      end
      if (o_mul_valid) begin
        mv_cnt++;
        if (mv_first < 0) mv_first = k;
      end
      if (o_rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_flush = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
    i_req_rs1 = '0; i_req_rs2 = '0; i_req_operation = '0;
    repeat (3) cyc();
    #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_mul_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b mul_valid=%b, required 1 0 0 0",
               o_req_ready, o_rsp_valid, o_busy, o_mul_valid);
    end
    checks++;
    if (o_rsp_data !== '0 || o_mul_rs1 !== '0 || o_mul_rs2 !== '0 || o_mul_operation !== '0) begin
      errors++;
      $display("FAIL reset_data: rsp_data=%h rs1=%h rs2=%h op=%b, required all zero",
               o_rsp_data, o_mul_rs1, o_mul_rs2, o_mul_operation);
    end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_miss();
    logic [3:0]  ops[4]  = '{OP_MULHU, OP_MULH, OP_MULHSU, OP_MUL};
    logic [31:0] as[4]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] bs[4]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd5};
    logic [31:0] exps[4] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_000F};
    bit rdy; int lat, mvf, mvc, chg; logic [31:0] r1, r2, e; logic [3:0] o;
    for (int i = 0; i < 4; i++) begin
      issue_req(ops[i], as[i], bs[i], exps[i], 1'b1, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL miss%0d_ready: got %b required 1", i, rdy); end
      wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
      checks++;
      if (r1 !== as[i] || r2 !== bs[i] || o !== ops[i]) begin
        errors++;
        $display("FAIL miss%0d_latch: got %h %h %b required %h %h %b", i, r1, r2, o, as[i], bs[i], ops[i]);
      end
      checks++;
      if (mvf != 1 || mvc != 1) begin
        errors++; $display("FAIL miss%0d_start: first=%0d count=%0d required 1 1", i, mvf, mvc);
      end
      checks++;
      if (lat != 19) begin errors++; $display("FAIL miss%0d_latency: got %0d required 19", i, lat); end
      checks++;
      if (chg != 0) begin errors++; $display("FAIL miss%0d_stable: %0d operand changes, required 0", i, chg); end
      e = exp_q.pop_front();
      checks++;
      if (o_rsp_data !== e || o_busy !== 1'b1) begin
        errors++; $display("FAIL miss%0d_data: got %h busy=%b required %h busy=1", i, o_rsp_data, o_busy, e);
      end
      i_rsp_ready = 1'b1;
      cyc();
      i_rsp_ready = 1'b0;
      #1;
      checks++;
      if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
        errors++; $display("FAIL miss%0d_handshake: rsp_valid=%b ready=%b required 0 1", i, o_rsp_valid, o_req_ready);
      end
    end
  endtask

  task automatic test_cache_hit();
    bit rdy; int lat, mvf, mvc, chg; logic [31:0] r1, r2, e; logic [3:0] o;
    issue_req(OP_MUL, 32'd3, 32'd5, 32'h0000_000F, 1'b1, rdy);
    wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
    checks++;
    if (lat != 1 || mvc != 0) begin
      errors++; $display("FAIL hit_latency: lat=%0d mul_valid_count=%0d required 1 0", lat, mvc);
    end
    e = exp_q.pop_front();
    checks++;
    if (o_rsp_data !== e) begin errors++; $display("FAIL hit_data: got %h required %h", o_rsp_data, e); end
    i_rsp_ready = 1'b1; cyc(); i_rsp_ready = 1'b0;
    // Same operands, different operation: must miss.
    issue_req(OP_MULH, 32'd3, 32'd5, 32'h0000_0000, 1'b1, rdy);
    wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
    checks++;
    if (lat != 19 || mvc != 1) begin
      errors++; $display("FAIL hit_opdiff: lat=%0d mul_valid_count=%0d required 19 1", lat, mvc);
    end
    e = exp_q.pop_front();
    checks++;
    if (o_rsp_data !== e) begin errors++; $display("FAIL hit_opdiff_data: got %h required %h", o_rsp_data, e); end
    i_rsp_ready = 1'b1; cyc(); i_rsp_ready = 1'b0;
  endtask

  task automatic test_flush_busy();
    bit rdy; int lat, mvf, mvc, chg, rdy_at, saw_rsp; logic [31:0] r1, r2, e; logic [3:0] o;
    issue_req(OP_MUL, 32'd7, 32'd9, 32'd63, 1'b0, rdy);
    for (int k = 1; k <= 5; k++) begin cyc(); i_req_valid = 1'b0; end
    cyc(); i_flush = 1'b1; #1;   // cycle t+6, fifth BUSY cycle
    checks++;
    if (o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
      errors++; $display("FAIL flushbusy_state: busy=%b ready=%b required 1 0", o_busy, o_req_ready);
    end
    rdy_at = -1; saw_rsp = 0;
    for (int k = 7; k <= 40; k++) begin
      cyc(); i_flush = 1'b0; #1;
      if (o_rsp_valid) saw_rsp++;
      if (o_req_ready) begin rdy_at = k; break; end
    end
    checks++;
    if (rdy_at != 19 || saw_rsp != 0) begin
      errors++; $display("FAIL flushbusy_drain: ready at t+%0d rsp_seen=%0d required t+19 0", rdy_at, saw_rsp);
    end
    issue_req(OP_MUL, 32'd7, 32'd9, 32'd63, 1'b1, rdy);
    wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
    checks++;
    if (lat != 19 || mvc != 1) begin
      errors++; $display("FAIL flushbusy_nocache: lat=%0d mul_valid_count=%0d required 19 1", lat, mvc);
    end
    e = exp_q.pop_front();
    checks++;
    if (o_rsp_data !== e) begin errors++; $display("FAIL flushbusy_data: got %h required %h", o_rsp_data, e); end
    i_rsp_ready = 1'b1; cyc(); i_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit rdy; int lat, mvf, mvc, chg, bad; logic [31:0] r1, r2, e, d0; logic [3:0] o;
    issue_req(OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b1, rdy);
    wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
    e = exp_q.pop_front();
    d0 = o_rsp_data; bad = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== d0) bad++;
    end
    checks++;
    if (lat != 19 || d0 !== e || bad != 0) begin
      errors++; $display("FAIL backpressure: lat=%0d data=%h unstable=%0d required 19 %h 0", lat, d0, bad, e);
    end
    i_rsp_ready = 1'b1; cyc(); i_rsp_ready = 1'b0;
    // Hit, then flush together with rsp_ready: response dropped.
    issue_req(OP_MUL, 32'h1234_5678, 32'h10, 32'h0, 1'b0, rdy);
    wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
    i_flush = 1'b1; i_rsp_ready = 1'b1;
    cyc(); i_flush = 1'b0; i_rsp_ready = 1'b0; #1;
    checks++;
    if (lat != 1 || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++; $display("FAIL resp_flush: lat=%0d rsp_valid=%b ready=%b required 1 0 1", lat, o_rsp_valid, o_req_ready);
    end
    // Cache survives the flush.
    issue_req(OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b1, rdy);
    wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
    e = exp_q.pop_front();
    checks++;
    if (lat != 1 || o_rsp_data !== e) begin
      errors++; $display("FAIL cache_after_flush: lat=%0d data=%h required 1 %h", lat, o_rsp_data, e);
    end
    i_rsp_ready = 1'b1; cyc(); i_rsp_ready = 1'b0;
  endtask

  task automatic test_flush_issue();
    bit rdy; int bad;
    issue_req(OP_MUL, 32'd11, 32'd13, 32'd143, 1'b0, rdy);
    cyc(); i_req_valid = 1'b0; i_flush = 1'b1; #1;
    checks++;
    if (o_mul_valid !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL flushissue_start: mul_valid=%b busy=%b required 0 1", o_mul_valid, o_busy);
    end
    cyc(); i_flush = 1'b0; #1;
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL flushissue_idle: ready=%b required 1", o_req_ready); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(); #1;
      if (o_rsp_valid || o_mul_valid || !o_req_ready) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL flushissue_quiet: %0d active cycles, required 0", bad); end
  endtask

  task automatic test_reset_mid_busy();
    bit rdy; int lat, mvf, mvc, chg; logic [31:0] r1, r2, e; logic [3:0] o;
    issue_req(OP_MUL, 32'd21, 32'd2, 32'd42, 1'b1, rdy);
    wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
    e = exp_q.pop_front();
    checks++;
    if (lat != 19 || o_rsp_data !== e) begin
      errors++; $display("FAIL rstbusy_fill: lat=%0d data=%h required 19 %h", lat, o_rsp_data, e);
    end
    i_rsp_ready = 1'b1; cyc(); i_rsp_ready = 1'b0;
    issue_req(OP_MULHU, 32'h8000_0000, 32'd4, 32'd0, 1'b0, rdy);
    for (int k = 1; k <= 6; k++) begin cyc(); i_req_valid = 1'b0; end
    rst_n = 1'b0; #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_mul_valid !== 1'b0 ||
        o_rsp_data !== '0 || o_mul_rs1 !== '0 || o_mul_rs2 !== '0 || o_mul_operation !== '0) begin
      errors++;
      $display("FAIL rstbusy_outputs: ready=%b rv=%b busy=%b mv=%b data=%h rs1=%h rs2=%h op=%b required reset values",
               o_req_ready, o_rsp_valid, o_busy, o_mul_valid, o_rsp_data, o_mul_rs1, o_mul_rs2, o_mul_operation);
    end
    cyc(); rst_n = 1'b1;
    issue_req(OP_MUL, 32'd21, 32'd2, 32'd42, 1'b1, rdy);
    wait_rsp(40, lat, mvf, mvc, chg, r1, r2, o);
    e = exp_q.pop_front();
    checks++;
    if (lat != 19 || mvc != 1 || o_rsp_data !== e) begin
      errors++; $display("FAIL rstbusy_cache: lat=%0d mvc=%0d data=%h required 19 1 %h", lat, mvc, o_rsp_data, e);
    end
    i_rsp_ready = 1'b1; cyc(); i_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss();
    test_cache_hit();
    test_flush_busy();
    test_backpressure();
    test_flush_issue();
    test_reset_mid_busy();
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
